seg_scoreboard: RTL and testbench
=================================

SEG_SCOREBOARD -- requirements
Module: seg_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, meaning maximum in-flight writes tracked per segment register (2-bit counter).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have ports issue_valid, input, 1 (decode presents an instruction) and pipe_hold, input, 1 (downstream stage not accepting).
REQ-005 SHALL have ports seg1_needed, seg2_needed, seg3_needed, input, 1 each, meaning the matching segment index is read.
REQ-006 SHALL have ports seg1, seg2, seg3, input, 3 each, meaning segment register indices (ES=0, CS=1, SS=2, DS=3, FS=4, GS=5; 6-7 unused).
REQ-007 SHALL have ports ld_seg, input, 1 (issuing instruction writes a segment register) and dseg, input, 3 (its destination index).
REQ-008 SHALL have ports wb_valid, input, 1, wb_ld_seg, input, 1, and wb_dseg, input, 3, meaning writeback of a segment register completes.
REQ-009 SHALL have port flush, input, 1, meaning pipeline flush; all in-flight writes are discarded.
REQ-010 SHALL have ports seg_stall, output, 1, issue_accept, output, 1, seg_busy, output, 8 (bit i = counter i nonzero), and wb_err, output, 1 (sticky underflow flag).

Function
REQ-011 SHALL keep one pending counter per index 0-7, range 0..MAX_PEND.
REQ-012 SHALL assert seg_stall combinationally when issue_valid and any segN_needed is set with counter[segN] nonzero.
REQ-013 SHALL also assert seg_stall when issue_valid, ld_seg, and counter[dseg] equals MAX_PEND (saturation).
REQ-014 SHALL drive issue_accept = issue_valid and not seg_stall and not pipe_hold and not flush.
REQ-015 SHALL increment counter[dseg] on the edge after a cycle with issue_accept and ld_seg.
REQ-016 SHALL decrement counter[wb_dseg] on the edge after a cycle with wb_valid and wb_ld_seg, when that counter is nonzero.
REQ-017 SHALL leave the counter unchanged when increment and decrement target the same index in the same cycle.
REQ-018 SHALL ignore a writeback to a zero counter and set wb_err, held until reset.
REQ-019 SHALL clear all counters on the edge after flush, with flush overriding issue and writeback that cycle; wb_err is unaffected.
REQ-020 SHALL not stall on a source that matches the issuing instruction's own dseg; only counter state is compared.
REQ-021 SHALL drive seg_busy from registered counter state with zero added latency; seg_stall releases the cycle after the decrement edge.
REQ-022 SHALL treat indices 6-7 like the others, with no special decode.

Reset
REQ-023 SHALL, on a clk edge with rst_n low, set all counters to 0 and wb_err to 0; seg_busy then reads 8'h00.
REQ-024 SHALL give reset priority over flush, issue and writeback; reset mid-operation discards all pending state.
REQ-025 SHALL hold seg_stall and issue_accept at 0 for the cycle following reset when issue_valid is low.

Structure
REQ-026 SHALL take segment index constants (ES, CS, SS, DS, FS, GS) and MAX_PEND from the shared decode include file, not local literals.
REQ-027 SHALL use sub-module seg_pend_ctr, one instance per index, with inc, dec, clr inputs and a count output, plus a nonzero flag and a saturated flag.
REQ-028 SHALL keep the compare and stall logic in the top level; the only state in the top level is the wb_err register.

Verification
REQ-029 SHALL cover basic RAW: issue ld_seg=1, dseg=3 accepted; next cycle seg1_needed=1, seg1=3 -> seg_stall=1; wb_dseg=3 -> seg_stall=0 one cycle later, seg_busy=8'h00.
REQ-030 SHALL cover saturation: three accepted writes to dseg=2 -> seg_busy[2]=1; a fourth write to dseg=2 -> seg_stall=1, issue_accept=0, counter stays 3.
REQ-031 SHALL cover simultaneous events: counter[0]=1, issue write dseg=0 plus writeback wb_dseg=0 in the same cycle -> counter stays 1.
REQ-032 SHALL cover underflow: wb_valid=1, wb_ld_seg=1, wb_dseg=5 with counter[5]=0 -> wb_err=1 and stays 1 through flush; seg_busy unchanged.
REQ-033 SHALL cover flush: counters 1, 2, 3 on ES, SS, DS, with flush plus an accepted issue in the same cycle -> seg_busy=8'h00 next cycle, no increment.
REQ-034 SHALL cover reset and hold: rst_n low mid-stream -> seg_busy=8'h00, wb_err=0; pipe_hold=1 with no dependency -> issue_accept=0, seg_stall=0, no counter change.

Source files
------------

// File: rtl/seg_scoreboard_pkg.sv
// Shared decode constants for the segment-register scoreboard: index names,
// the default pending-write depth and the counter width helper.
package seg_scoreboard_pkg;

    localparam int NUM_SEGS         = 8;
    localparam int DEFAULT_MAX_PEND = 3;

    typedef logic [2:0] seg_idx_t;

    typedef enum logic [2:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5,
        SEG_R6 = 3'd6,
        SEG_R7 = 3'd7
    } seg_name_e;

    function automatic int ctr_width(int max_pend);
        return (max_pend < 2) ? 1 : $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/seg_scoreboard_if.sv
// Decode/writeback-side signal bundle of the segment scoreboard.
interface seg_scoreboard_if;
    import seg_scoreboard_pkg::*;

    logic                issue_valid;
    logic                pipe_hold;
    logic                seg1_needed;
    logic                seg2_needed;
    logic                seg3_needed;
    seg_idx_t            seg1;
    seg_idx_t            seg2;
    seg_idx_t            seg3;
    logic                ld_seg;
    seg_idx_t            dseg;
    logic                wb_valid;
    logic                wb_ld_seg;
    seg_idx_t            wb_dseg;
    logic                flush;
    logic                seg_stall;
    logic                issue_accept;
    logic [NUM_SEGS-1:0] seg_busy;
    logic                wb_err;

    modport master (
        output issue_valid, pipe_hold, seg1_needed, seg2_needed, seg3_needed,
               seg1, seg2, seg3, ld_seg, dseg, wb_valid, wb_ld_seg, wb_dseg, flush,
        input  seg_stall, issue_accept, seg_busy, wb_err
    );

    modport slave (
        input  issue_valid, pipe_hold, seg1_needed, seg2_needed, seg3_needed,
               seg1, seg2, seg3, ld_seg, dseg, wb_valid, wb_ld_seg, wb_dseg, flush,
        output seg_stall, issue_accept, seg_busy, wb_err
    );

endinterface

// File: rtl/seg_pend_ctr.sv
// Pending-write counter for one segment register; clear wins over inc/dec,
// and a simultaneous inc and dec cancel out.
module seg_pend_ctr #(
    parameter int MAX_PEND = 3,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          saturated
);

    assign nonzero   = (count != '0);
    assign saturated = (count == CW'(MAX_PEND));

    // Guards keep the counter in range even if the caller misbehaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !saturated) begin
            count <= count + CW'(1);
        end else if (dec && !inc && nonzero) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/seg_scoreboard.sv
// Segment-register RAW scoreboard: per-index pending counters, issue stall
// and accept generation, and a sticky writeback-underflow flag.
module seg_scoreboard
    import seg_scoreboard_pkg::*;
#(
    parameter int MAX_PEND = DEFAULT_MAX_PEND
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scoreboard_if.slave sb
);

    localparam int CW = ctr_width(MAX_PEND);

    logic [NUM_SEGS-1:0] inc_vec;
    logic [NUM_SEGS-1:0] dec_vec;
    logic [NUM_SEGS-1:0] nz_vec;
    logic [NUM_SEGS-1:0] sat_vec;
    logic [NUM_SEGS-1:0] busy_vec;
    logic [CW-1:0]       count_arr [NUM_SEGS];

    logic src_hit;
    logic sat_hit;
    logic stall;
    logic accept;
    logic wb_fire;
    logic underflow;
    logic wb_err_q;

    // Only registered counter state is compared, so an instruction never stalls on its own dseg.
    always_comb begin
        src_hit   = (sb.seg1_needed && nz_vec[sb.seg1])
                 || (sb.seg2_needed && nz_vec[sb.seg2])
                 || (sb.seg3_needed && nz_vec[sb.seg3]);
        sat_hit   = sb.ld_seg && sat_vec[sb.dseg];
        stall     = sb.issue_valid && (src_hit || sat_hit);
        accept    = sb.issue_valid && !stall && !sb.pipe_hold && !sb.flush;
        wb_fire   = sb.wb_valid && sb.wb_ld_seg && !sb.flush;
        underflow = wb_fire && !nz_vec[sb.wb_dseg];
    end

    for (genvar i = 0; i < NUM_SEGS; i++) begin : g_ctr
        assign inc_vec[i]  = accept && sb.ld_seg && (sb.dseg == seg_idx_t'(i));
        assign dec_vec[i]  = wb_fire && (sb.wb_dseg == seg_idx_t'(i)) && nz_vec[i];
        assign busy_vec[i] = |count_arr[i];

        seg_pend_ctr #(
            .MAX_PEND (MAX_PEND),
            .CW       (CW)
        ) u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .clr       (sb.flush),
            .count     (count_arr[i]),
            .nonzero   (nz_vec[i]),
            .saturated (sat_vec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_err_q <= 1'b0;
        end else if (underflow) begin
            wb_err_q <= 1'b1;
        end
    end

    assign sb.seg_stall    = stall;
    assign sb.issue_accept = accept;
    assign sb.seg_busy     = busy_vec;
    assign sb.wb_err       = wb_err_q;

endmodule

// File: tb/tb_seg_scoreboard.sv
// Self-checking bench for seg_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a counter-array reference model.
module tb_seg_scoreboard;
    import seg_scoreboard_pkg::*;

    localparam int MAXP = 3;

    typedef struct {
        bit       iv, hold, n1, n2, n3, ld, wv, wl, fl, rn;
        bit [2:0] s1, s2, s3, d, wd;
    } stim_t;

    logic clk;
    logic rst_n;
    seg_scoreboard_if sbif();

    seg_scoreboard #(.MAX_PEND(MAXP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    cnt [8];
    bit    err;
    string phase;

    logic       obs_stall, obs_accept, obs_err;
    logic [7:0] obs_busy;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rn = 1'b1;
        return s;
    endfunction

    // One cycle: drive at negedge, check mid-cycle, advance the model at posedge.
    task automatic applyStimulus(input stim_t s);
        bit         e_stall, e_acc, incr, decr;
        logic [7:0] e_busy;
        @(negedge clk);
        sbif.issue_valid = s.iv;  sbif.pipe_hold = s.hold;
        sbif.seg1_needed = s.n1;  sbif.seg2_needed = s.n2; sbif.seg3_needed = s.n3;
        sbif.seg1 = s.s1;  sbif.seg2 = s.s2;  sbif.seg3 = s.s3;
        sbif.ld_seg = s.ld;  sbif.dseg = s.d;
        sbif.wb_valid = s.wv;  sbif.wb_ld_seg = s.wl;  sbif.wb_dseg = s.wd;
        sbif.flush = s.fl;  rst_n = s.rn;
        #1;
        e_stall = s.iv && ((s.n1 && cnt[s.s1] > 0) || (s.n2 && cnt[s.s2] > 0) ||
                           (s.n3 && cnt[s.s3] > 0) || (s.ld && cnt[s.d] == MAXP));
        e_acc   = s.iv && !e_stall && !s.hold && !s.fl;
        for (int i = 0; i < 8; i++) e_busy[i] = (cnt[i] != 0);
        obs_stall = sbif.seg_stall;  obs_accept = sbif.issue_accept;
        obs_busy  = sbif.seg_busy;   obs_err    = sbif.wb_err;
        checkOutput({phase, ".stall"},  32'(obs_stall),  32'(e_stall));
        checkOutput({phase, ".accept"}, 32'(obs_accept), 32'(e_acc));
        checkOutput({phase, ".busy"},   32'(obs_busy),   32'(e_busy));
        checkOutput({phase, ".wb_err"}, 32'(obs_err),    32'(err));
        @(posedge clk);
        if (!s.rn) begin
            foreach (cnt[i]) cnt[i] = 0;
            err = 1'b0;
        end else if (s.fl) begin
            foreach (cnt[i]) cnt[i] = 0;
        end else begin
            incr = e_acc && s.ld;
            decr = s.wv && s.wl && cnt[s.wd] > 0;
            if (s.wv && s.wl && cnt[s.wd] == 0) err = 1'b1;
            if (!(incr && decr && s.d == s.wd)) begin
                if (incr) cnt[s.d]++;
                if (decr) cnt[s.wd]--;
            end
        end
    endtask

    function automatic stim_t wr(input bit [2:0] d);
        stim_t s = idle();
        s.iv = 1'b1; s.ld = 1'b1; s.d = d;
        return s;
    endfunction

    function automatic stim_t wb(input bit [2:0] wd);
        stim_t s = idle();
        s.wv = 1'b1; s.wl = 1'b1; s.wd = wd;
        return s;
    endfunction

    function automatic bit [2:0] pick_wd();
        int start = $urandom_range(0, 7);
        if ($urandom_range(0, 4) != 0)
            for (int k = 0; k < 8; k++)
                if (cnt[(start + k) % 8] > 0) return 3'((start + k) % 8);
        return 3'(start);
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        sbif.issue_valid = 0; sbif.pipe_hold = 0; sbif.seg1_needed = 0;
        sbif.seg2_needed = 0; sbif.seg3_needed = 0; sbif.seg1 = 0; sbif.seg2 = 0;
        sbif.seg3 = 0; sbif.ld_seg = 0; sbif.dseg = 0; sbif.wb_valid = 0;
        sbif.wb_ld_seg = 0; sbif.wb_dseg = 0; sbif.flush = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        foreach (cnt[i]) cnt[i] = 0;
        err = 1'b0;

        phase = "reset";
        applyStimulus(idle());
        checkOutput("reset.busy_zero", 32'(obs_busy), 32'h0);
        checkOutput("reset.accept_low", 32'(obs_accept), 32'h0);

        phase = "raw";
        applyStimulus(wr(3'(SEG_DS)));
        checkOutput("raw.accept", 32'(obs_accept), 32'h1);
        s = idle(); s.iv = 1; s.n1 = 1; s.s1 = 3'(SEG_DS);
        applyStimulus(s);
        checkOutput("raw.stall_set", 32'(obs_stall), 32'h1);
        s.wv = 1; s.wl = 1; s.wd = 3'(SEG_DS);
        applyStimulus(s);
        s.wv = 0;
        applyStimulus(s);
        checkOutput("raw.stall_released", 32'(obs_stall), 32'h0);
        checkOutput("raw.busy_clear", 32'(obs_busy), 32'h0);

        phase = "sat";
        repeat (3) applyStimulus(wr(3'(SEG_SS)));
        applyStimulus(wr(3'(SEG_SS)));
        checkOutput("sat.busy2", 32'(obs_busy[2]), 32'h1);
        checkOutput("sat.stall", 32'(obs_stall), 32'h1);
        checkOutput("sat.no_accept", 32'(obs_accept), 32'h0);
        repeat (2) applyStimulus(wb(3'(SEG_SS)));
        applyStimulus(wb(3'(SEG_SS)));
        checkOutput("sat.still_busy_before_last", 32'(obs_busy[2]), 32'h1);
        applyStimulus(idle());
        checkOutput("sat.drained", 32'(obs_busy), 32'h0);
        checkOutput("sat.no_err", 32'(obs_err), 32'h0);

        phase = "simul";
        applyStimulus(wr(3'(SEG_ES)));
        s = wr(3'(SEG_ES)); s.wv = 1; s.wl = 1; s.wd = 3'(SEG_ES);
        applyStimulus(s);
        applyStimulus(wb(3'(SEG_ES)));
        checkOutput("simul.count_one", 32'(obs_busy), 32'h1);
        applyStimulus(idle());
        checkOutput("simul.drained", 32'(obs_busy), 32'h0);

        phase = "underflow";
        applyStimulus(wb(3'(SEG_GS)));
        applyStimulus(idle());
        checkOutput("underflow.err", 32'(obs_err), 32'h1);
        checkOutput("underflow.busy", 32'(obs_busy), 32'h0);

        phase = "flush";
        applyStimulus(wr(3'(SEG_ES)));
        repeat (2) applyStimulus(wr(3'(SEG_SS)));
        repeat (3) applyStimulus(wr(3'(SEG_DS)));
        s = wr(3'(SEG_CS)); s.fl = 1;
        applyStimulus(s);
        checkOutput("flush.busy_before", 32'(obs_busy), 32'h0D);
        checkOutput("flush.no_accept", 32'(obs_accept), 32'h0);
        applyStimulus(idle());
        checkOutput("flush.busy_after", 32'(obs_busy), 32'h0);
        checkOutput("flush.err_kept", 32'(obs_err), 32'h1);

        phase = "rst_hold";
        applyStimulus(wr(3'(SEG_FS)));
        s = idle(); s.rn = 0;
        applyStimulus(s);
        applyStimulus(idle());
        checkOutput("rst.busy", 32'(obs_busy), 32'h0);
        checkOutput("rst.err", 32'(obs_err), 32'h0);
        s = wr(3'(SEG_CS)); s.hold = 1;
        applyStimulus(s);
        checkOutput("hold.accept", 32'(obs_accept), 32'h0);
        checkOutput("hold.stall", 32'(obs_stall), 32'h0);
        applyStimulus(idle());
        checkOutput("hold.busy", 32'(obs_busy), 32'h0);

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            s      = idle();
            s.iv   = $urandom_range(0, 3) != 0;
            s.hold = $urandom_range(0, 5) == 0;
            s.n1   = $urandom_range(0, 3) == 0;
            s.n2   = $urandom_range(0, 3) == 0;
            s.n3   = $urandom_range(0, 3) == 0;
            s.s1   = 3'($urandom_range(0, 7));
            s.s2   = 3'($urandom_range(0, 7));
            s.s3   = 3'($urandom_range(0, 7));
            s.ld   = $urandom_range(0, 1) != 0;
            s.d    = 3'($urandom_range(0, 7));
            s.fl   = $urandom_range(0, 29) == 0;
            if (!s.fl) begin
                s.wv = $urandom_range(0, 2) == 0;
                s.wl = $urandom_range(0, 7) != 0;
                s.wd = pick_wd();
            end
            s.rn = $urandom_range(0, 79) != 0;
            applyStimulus(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
